// File: rtl/sliced_add_sequencer.sv
// Full-width adder sequenced over an external SLICE-bit adder, one slice per clock,
// least-significant slice first, with a valid/ready operand port and a valid/ready result port.
module sliced_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  output logic [SLICE-1:0] add_a,
  output logic [SLICE-1:0] add_b,
  output logic             add_ci,
  input  logic [SLICE-1:0] add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_co_q, out_co_d;

  // Next-state logic; out_sum_q mirrors the sum register only from DONE onwards,
  // so the visible result holds while the next operation clears and rebuilds the sum.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    out_sum_d = out_sum_q;
    out_co_d  = out_co_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_c;
          idx_d   = {IW{1'b0}};
          sum_d   = {WIDTH{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*SLICE +: SLICE] = add_s;
        carry_d = add_co;
        if (idx_q == LAST_IDX) begin
          idx_d     = {IW{1'b0}};
          out_sum_d = sum_d;
          out_co_d  = add_co;
          state_d   = S_DONE;
        end else begin
          idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= {IW{1'b0}};
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      sum_q     <= {WIDTH{1'b0}};
      carry_q   <= 1'b0;
      out_sum_q <= {WIDTH{1'b0}};
      out_co_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_sum_q <= out_sum_d;
      out_co_q  <= out_co_d;
    end
  end

  // Slice adder drive is gated to RUN so the adder sees zeros otherwise.
  always_comb begin
    add_a  = {SLICE{1'b0}};
    add_b  = {SLICE{1'b0}};
    add_ci = 1'b0;
    if (state_q == S_RUN) begin
      add_a  = a_q[int'(idx_q)*SLICE +: SLICE];
      add_b  = b_q[int'(idx_q)*SLICE +: SLICE];
      add_ci = carry_q;
    end else begin
      add_a  = {SLICE{1'b0}};
      add_b  = {SLICE{1'b0}};
      add_ci = 1'b0;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = out_sum_q;
  assign out_co    = out_co_q;

endmodule
